// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round/schedule helper functions.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_e;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-deep SHA-256 message schedule: passes streamed words through for rounds 0-15,
// expands with the small sigmas afterwards.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        take_input,
  input  logic [31:0] w_in,
  output logic [31:0] w_t
);

  // sched_q[15] holds W[t-1], sched_q[0] holds W[t-16]
  logic [31:0] sched_q [16];

  always_comb begin
    if (take_input) begin
      w_t = w_in;
    end else begin
      w_t = small_s1(sched_q[14]) + sched_q[9] + small_s0(sched_q[1]) + sched_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) sched_q[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < 15; i++) sched_q[i] <= sched_q[i + 1];
      sched_q[15] <= w_t;
    end
  end

endmodule

// File: rtl/sha256_stream_core.sv
// SHA-256 compression core: streamed 16-word chunk input, one round per cycle, chained H.
// Define SHA224_MODE_EN to honour mode224 (SHA-224 IV and digest truncation).
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter bit          SWAP_OUT = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             mode224,
  input  logic             start,
  input  logic             last,
  input  logic             w_valid,
  input  logic [31:0]      w_in,
  output logic             w_ready,
  output logic             busy,
  output logic             digest_valid,
  output logic [255:0]     digest,
  output logic [CNT_W-1:0] chunk_cnt
);

  state_e           state_q, state_d;
  logic [5:0]       round_q;
  logic [31:0]      h_q [8];
  logic [31:0]      work_q [8];
  logic [31:0]      iv [8];
  logic             last_q;
  logic [CNT_W-1:0] chunk_cnt_q;

  logic        idle_like, init_take, start_take, early_round, advance;
  logic [31:0] w_t, t1, t2, out_word;

  assign idle_like   = (state_q == IDLE) || (state_q == DONE);
  assign init_take   = idle_like && init;
  assign start_take  = idle_like && start;
  assign early_round = (round_q[5:4] == 2'b00);
  assign advance     = (state_q == ROUND) && (!early_round || w_valid);

  assign w_ready      = (state_q == ROUND) && early_round;
  assign busy         = (state_q != IDLE);
  assign digest_valid = (state_q == DONE);
  assign chunk_cnt    = chunk_cnt_q;

`ifdef SHA224_MODE_EN
  logic mode_q;

  always_comb begin
    for (int i = 0; i < 8; i++) iv[i] = mode224 ? IV224[i] : IV256[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (init_take) begin
      mode_q <= mode224;
    end
  end
`else
  logic mode224_unused;
  assign mode224_unused = mode224;

  always_comb begin
    for (int i = 0; i < 8; i++) iv[i] = IV256[i];
  end
`endif

  sha256_msg_schedule u_sched (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (advance),
    .take_input (early_round),
    .w_in       (w_in),
    .w_t        (w_t)
  );

  always_comb begin
    t1 = work_q[7] + big_s1(work_q[4]) + ch(work_q[4], work_q[5], work_q[6]) + K[round_q] + w_t;
    t2 = big_s0(work_q[0]) + maj(work_q[0], work_q[1], work_q[2]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
        end else if (init) begin
          state_d = IDLE;
        end
      end
      LOAD:    state_d = ROUND;
      ROUND:   if (advance && (round_q == 6'd63)) state_d = FINAL;
      FINAL:   state_d = last_q ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= '0;
      last_q      <= 1'b0;
      chunk_cnt_q <= '0;
      for (int i = 0; i < 8; i++) begin
        h_q[i]    <= IV256[i];
        work_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (init_take) begin
        for (int i = 0; i < 8; i++) h_q[i] <= iv[i];
        chunk_cnt_q <= '0;
      end
      if (start_take) last_q <= last;
      if (state_q == LOAD) begin
        for (int i = 0; i < 8; i++) work_q[i] <= h_q[i];
        round_q <= '0;
      end
      if (advance) begin
        work_q[0] <= t1 + t2;
        work_q[1] <= work_q[0];
        work_q[2] <= work_q[1];
        work_q[3] <= work_q[2];
        work_q[4] <= work_q[3] + t1;
        work_q[5] <= work_q[4];
        work_q[6] <= work_q[5];
        work_q[7] <= work_q[6];
        round_q   <= round_q + 6'd1;
      end
      if (state_q == FINAL) begin
        for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + work_q[i];
        chunk_cnt_q <= chunk_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    digest   = '0;
    out_word = '0;
    for (int i = 0; i < 8; i++) begin
      out_word = h_q[i];
`ifdef SHA224_MODE_EN
      if ((i == 7) && mode_q) out_word = '0;
`endif
      digest[255 - 32 * i -: 32] = SWAP_OUT ? bswap32(out_word) : out_word;
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Directed bench for sha256_stream_core: known-answer digests, latency, stalls, reset, busy rules.
module tb_sha256_stream_core;

  typedef logic [31:0] blk_t [16];

  localparam logic [255:0] IV_256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_ABC224 =
    256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

  logic         clk = 1'b0;
  logic         rst_n, init, mode224, start, last, w_valid;
  logic [31:0]  w_in;
  logic         w_ready, busy, digest_valid;
  logic [255:0] digest;
  logic [15:0]  chunk_cnt;
  logic         w_ready_sw, busy_sw, digest_valid_sw;
  logic [255:0] digest_sw;
  logic [15:0]  chunk_cnt_sw;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sha256_stream_core #(.SWAP_OUT(1'b0), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .mode224      (mode224),
    .start        (start),
    .last         (last),
    .w_valid      (w_valid),
    .w_in         (w_in),
    .w_ready      (w_ready),
    .busy         (busy),
    .digest_valid (digest_valid),
    .digest       (digest),
    .chunk_cnt    (chunk_cnt)
  );

  sha256_stream_core #(.SWAP_OUT(1'b1), .CNT_W(16)) dut_sw (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .mode224      (mode224),
    .start        (start),
    .last         (last),
    .w_valid      (w_valid),
    .w_in         (w_in),
    .w_ready      (w_ready_sw),
    .busy         (busy_sw),
    .digest_valid (digest_valid_sw),
    .digest       (digest_sw),
    .chunk_cnt    (chunk_cnt_sw)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] swap_words(input logic [255:0] d);
    logic [255:0] r;
    logic [31:0]  w;
    for (int i = 0; i < 8; i++) begin
      w = d[32 * i +: 32];
      r[32 * i +: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    return r;
  endfunction

  task automatic do_init(input logic m);
    @(negedge clk);
    init = 1'b1;
    mode224 = m;
    @(negedge clk);
    init = 1'b0;
    mode224 = 1'b0;
  endtask

  // lat counts negedges after the start-sampling edge until the exit condition is seen
  task automatic run_chunk(input blk_t blk, input logic lst, input bit with_init,
                           input bit stall, input int poke, input int abort_at,
                           output int lat);
    int n;
    int i;
    bit phase;
    bit done;
    n = 0;
    i = 0;
    phase = 1'b0;
    done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    last = lst;
    init = with_init;
    mode224 = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      last = 1'b0;
      init = 1'b0;
      mode224 = 1'b0;
      if (n == poke) begin
        start = 1'b1;
        init = 1'b1;
        mode224 = 1'b1;
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        done = 1'b1;
      end else if (lst ? digest_valid : (n > 2 && !busy)) begin
        done = 1'b1;
      end else if (i < 16 && w_ready) begin
        if (stall && !phase) begin
          w_valid = 1'b0;
          phase = 1'b1;
        end else begin
          w_valid = 1'b1;
          w_in = blk[i];
          i++;
          phase = 1'b0;
        end
      end else begin
        w_valid = 1'b0;
      end
    end
    w_valid = 1'b0;
    lat = n;
    check_eq("chunk_finished_in_bound", done, 1);
  endtask

  initial begin
    blk_t blk_abc, blk_empty, blk_two1, blk_two2;
    int   lat;

    for (int i = 0; i < 16; i++) begin
      blk_abc[i] = '0;
      blk_empty[i] = '0;
      blk_two2[i] = '0;
    end
    blk_abc[0] = 32'h61626380;
    blk_abc[15] = 32'h00000018;
    blk_empty[0] = 32'h80000000;
    blk_two2[15] = 32'h000001c0;
    blk_two1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};

    rst_n = 1'b0;
    init = 1'b0;
    mode224 = 1'b0;
    start = 1'b0;
    last = 1'b0;
    w_valid = 1'b0;
    w_in = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_digest", digest, IV_256);
    check_eq("reset_digest_swapped", digest_sw, swap_words(IV_256));
    check_eq("reset_digest_valid", digest_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_chunk_cnt", chunk_cnt, 0);
    check_eq("reset_w_ready", w_ready, 0);
    rst_n = 1'b1;

    // "abc", unstalled
    do_init(1'b0);
    run_chunk(blk_abc, 1'b1, 1'b0, 1'b0, 0, 0, lat);
    check_eq("abc_latency", lat, 67);
    check_eq("abc_digest", digest, D_ABC);
    check_eq("abc_digest_swapped", digest_sw, swap_words(D_ABC));
    check_eq("abc_swapped_word0", digest_sw[255:224], 32'hbf1678ba);
    check_eq("abc_chunk_cnt", chunk_cnt, 1);
    check_eq("abc_digest_valid", digest_valid, 1);

    // two-chunk message, second chunk chains from H without init
    do_init(1'b0);
    run_chunk(blk_two1, 1'b0, 1'b0, 1'b0, 0, 0, lat);
    check_eq("two_mid_busy", busy, 0);
    check_eq("two_mid_digest_valid", digest_valid, 0);
    check_eq("two_mid_chunk_cnt", chunk_cnt, 1);
    run_chunk(blk_two2, 1'b1, 1'b0, 1'b0, 0, 0, lat);
    check_eq("two_digest", digest, D_TWO);
    check_eq("two_chunk_cnt", chunk_cnt, 2);

    // empty message with one idle cycle in front of every word
    do_init(1'b0);
    run_chunk(blk_empty, 1'b1, 1'b0, 1'b1, 0, 0, lat);
    check_eq("empty_stalled_latency", lat, 67 + 16);
    check_eq("empty_digest", digest, D_EMPTY);

    do_init(1'b1);
    run_chunk(blk_abc, 1'b1, 1'b0, 1'b0, 0, 0, lat);
`ifdef SHA224_MODE_EN
    check_eq("abc224_digest", digest, D_ABC224);
    check_eq("abc224_digest_swapped", digest_sw, swap_words(D_ABC224));
`else
    check_eq("mode224_ignored_digest", digest, D_ABC);
`endif

    // reset asserted at round 30 (round r is seen at negedge r+2)
    do_init(1'b0);
    run_chunk(blk_abc, 1'b1, 1'b0, 1'b0, 0, 32, lat);
    #1;
    check_eq("abort_digest", digest, IV_256);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_chunk_cnt", chunk_cnt, 0);
    check_eq("abort_digest_valid", digest_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // rerun with init and start in the same cycle
    run_chunk(blk_abc, 1'b1, 1'b1, 1'b0, 0, 0, lat);
    check_eq("rerun_digest", digest, D_ABC);
    check_eq("rerun_chunk_cnt", chunk_cnt, 1);
    check_eq("rerun_latency", lat, 67);

    // init/start/mode224 pulsed mid-ROUND must be ignored
    do_init(1'b0);
    run_chunk(blk_abc, 1'b1, 1'b0, 1'b0, 40, 0, lat);
    check_eq("poke_digest", digest, D_ABC);
    check_eq("poke_chunk_cnt", chunk_cnt, 1);
    check_eq("poke_latency", lat, 67);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Next-generation SHA-256 compression engine: owns the round counter, K constants and the message schedule.
- Accepts a 512-bit chunk as 16 streamed 32-bit words with a valid/ready handshake and runs 64 rounds, one round per cycle.
- Chains the intermediate hash across chunks and presents a 256-bit digest with a valid flag.
- Sits between the AXI/DMA word-feeder and the register bank in the Zynq SHA-256 accelerator.

Parameters:
- SWAP_OUT, 1: 1 = byte-swap each digest word (little-endian bus view); 0 = raw big-endian words.
- CNT_W, 16: width of the chunk counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- init  in  1  pulse; reload IV and clear the chunk count; honoured only in IDLE
- mode224  in  1  sampled on init; 1 = SHA-224 IV and truncation
- start  in  1  pulse; begin a chunk; honoured only in IDLE
- last  in  1  sampled with start; marks the final chunk of the message
- w_valid  in  1  message word valid
- w_in  in  32  message word, big-endian, W0 first
- w_ready  out  1  high in ROUND while round_cnt < 16
- busy  out  1  high when state != IDLE
- digest_valid  out  1  high from DONE until next init/start; reset 0
- digest  out  256  H0 at [255:224]; reset = SHA-256 IV (swapped if SWAP_OUT)
- chunk_cnt  out  CNT_W  chunks completed since init; reset 0; wraps

Behaviour:
- Reset values: state IDLE, H = SHA-256 IV, working registers and schedule = 0, round_cnt = 0, mode = 256.
- Reset asserted mid-chunk aborts immediately to these values; no partial H update is kept.
- FSM IDLE -> LOAD -> ROUND -> FINAL -> (DONE or IDLE):
  - IDLE: start -> LOAD; last and start latched.
  - LOAD (1 cycle): a..h <= H; round_cnt <= 0.
  - ROUND, rounds 0-15: advance only on w_valid & w_ready. W = w_in, pushed into a 16-deep schedule shift register.
  - ROUND, rounds 16-63: advance every cycle. W = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32. w_ready = 0.
  - ROUND, every advancing cycle: standard update T1 = h+S1+ch+K[t]+W, T2 = S0+maj, all sums mod 2^32. Round 63 -> FINAL.
  - FINAL (1 cycle): H[i] <= H[i] + working[i]; chunk_cnt++. Latched last -> DONE, else -> IDLE.
  - DONE: digest_valid = 1; hold until init or start. Either clears digest_valid and is processed as in IDLE.
- Latency without stalls: start at edge T0 -> LOAD T0+1, rounds T0+2..T0+65, FINAL T0+66, digest_valid high at T0+67.
- Each cycle of w_valid low during rounds 0-15 adds one cycle of latency.
- init and start in the same cycle: IV loaded and the chunk starts from the IV.
- init or start while busy (LOAD/ROUND/FINAL): ignored, no side effect.
- start without a prior init after DONE: chains from the current H (message continuation is the caller's choice).
- mode224 = 1: SHA-224 IV loaded on init; digest[31:0] forced to 0.
- digest is combinational from H and is meaningful only while digest_valid = 1.

Optional Feature:
- SHA224_MODE_EN defined: mode224 honoured as above.
- Undefined: mode224 ignored; mode is fixed at SHA-256; no SHA-224 IV logic or truncation mux is synthesised; port still present.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant array, IV256[0:7] and IV224[0:7];
  - the state enum {IDLE, LOAD, ROUND, FINAL, DONE};
  - functions rotr, big_s0, big_s1, small_s0, small_s1, ch, maj, bswap32.
- Sub-module sha256_msg_schedule holds the 16x32 shift register, small-sigma expansion, and the load/advance controls driven by the core FSM.

Test Plan:
- SHA-256 of "abc" (padded single chunk, last = 1, w_valid always high): digest_valid at T0+67; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad (SWAP_OUT = 0); chunk_cnt = 1.
- SHA-256 of the 56-byte "abcdbcdecdef...nopq" (two chunks: first last = 0, second last = 1):
  - after chunk 1: busy = 0, digest_valid = 0;
  - final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; chunk_cnt = 2.
- SHA-256 of the empty message with w_valid toggling 1/0 each cycle: digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; digest_valid asserts 16 cycles later than unstalled.
- With SHA224_MODE_EN, init with mode224 = 1, then "abc": digest = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Reset and busy rules:
  - rst_n low at round 30: digest = IV, busy = 0, chunk_cnt = 0.
  - Re-running "abc" gives the correct digest.
  - start/init pulsed during ROUND change nothing.
- SWAP_OUT = 1, "abc": digest word0 = bf1678ba; all words byte-reversed versus the SWAP_OUT = 0 result.
